// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_sequencer
//  Description : Multicycle fetch/decode/execute/writeback sequencer for the
//                8-bit core. Fetches 9-bit instructions from a combinational
//                ROM, decodes them into ALU fields, and drives the register
//                file and data-memory strobes. Handles the B (PC-relative) and
//                BTRU (absolute, taken when AluZero is low) branches, and stops
//                on the halt word.
//  Ports       : Clk, Reset (async, active-high), Start (run pulse)
//                InstrIn      - ROM data at address PC
//                AluZero      - ALU zero flag for the current operation
//                BranchTarget - register-file ReadB value, BTRU target
//                PC           - instruction address
//                OpType/ROperand/IOperand/Immediate - ALU operation fields
//                RegAddrA/RegAddrB - register-file addresses
//                RegWrEn/MemWrEn/MemRdEn - write/read strobes
//                Busy, Done, CycleCount - run status
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int         PCW       = 8,
    parameter logic [8:0] HALT_WORD = 9'h1FF
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    input  wire logic           Start,
    input  wire logic [8:0]     InstrIn,
    input  wire logic           AluZero,
    input  wire logic [7:0]     BranchTarget,
    output logic [PCW-1:0]      PC,
    output logic                OpType,
    output logic [3:0]          ROperand,
    output logic [2:0]          IOperand,
    output logic [4:0]          Immediate,
    output logic [1:0]          RegAddrA,
    output logic [1:0]          RegAddrB,
    output logic                RegWrEn,
    output logic                MemWrEn,
    output logic                MemRdEn,
    output logic                Busy,
    output logic                Done,
    output logic [15:0]         CycleCount
);

    // Opcode encodings shared with the ALU operations package
    localparam logic [3:0] c_OP_LOAD = 4'hC;
    localparam logic [3:0] c_OP_STR  = 4'hD;
    localparam logic [3:0] c_OP_BTRU = 4'hE;
    localparam logic [2:0] c_OP_B    = 3'b110;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_FETCH     = 3'd1;
    localparam logic [2:0] c_ST_DECODE    = 3'd2;
    localparam logic [2:0] c_ST_EXECUTE   = 3'd3;
    localparam logic [2:0] c_ST_WRITEBACK = 3'd4;
    localparam logic [2:0] c_ST_DONE      = 3'd5;

    localparam logic [PCW-1:0] c_PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
    localparam logic [15:0]    c_CNT_MAX = 16'hFFFF;

    logic [2:0]     r_state;
    logic [2:0]     w_state_next;
    logic [8:0]     r_ir;
    logic [PCW-1:0] r_pc;
    logic [15:0]    r_cnt;
    logic           r_take_br;
    logic [PCW-1:0] r_br_target;

    logic           w_busy;
    logic           w_start_run;
    logic           w_is_itype;
    logic           w_is_str;
    logic           w_is_load;
    logic           w_is_btru;
    logic           w_is_b;
    logic [PCW-1:0] w_imm_ext;
    logic [PCW-1:0] w_bt;
    logic [PCW-1:0] w_pc_next;
    logic           w_regwr;
    logic           w_memwr;
    logic           w_memrd;

    // BranchTarget is always 8 bits; fit it to the PC width
    generate
        if (PCW > 8) begin : g_bt_wide
            assign w_bt = {{(PCW-8){1'b0}}, BranchTarget};
        end else if (PCW == 8) begin : g_bt_exact
            assign w_bt = BranchTarget;
        end else begin : g_bt_narrow
            assign w_bt = BranchTarget[PCW-1:0];
        end
    endgenerate

    // Field decode straight from the instruction register; IR only changes on
    // the FETCH edge, so the fields are stable from DECODE through WRITEBACK
    assign w_is_itype = r_ir[8];
    assign w_is_str   = !w_is_itype && (r_ir[7:4] == c_OP_STR);
    assign w_is_load  = !w_is_itype && (r_ir[7:4] == c_OP_LOAD);
    assign w_is_btru  = !w_is_itype && (r_ir[7:4] == c_OP_BTRU);
    assign w_is_b     =  w_is_itype && (r_ir[7:5] == c_OP_B);
    assign w_imm_ext  = {{(PCW-5){r_ir[4]}}, r_ir[4:0]};

    assign w_busy      = (r_state == c_ST_FETCH)   || (r_state == c_ST_DECODE) ||
                         (r_state == c_ST_EXECUTE) || (r_state == c_ST_WRITEBACK);
    assign w_start_run = Start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    always_comb begin
        if (w_is_b)
            w_pc_next = r_pc + w_imm_ext;
        else if (r_take_br)
            w_pc_next = r_br_target;
        else
            w_pc_next = r_pc + c_PC_ONE;
    end

    // Next-state and strobe logic
    always_comb begin
        w_state_next = r_state;
        w_regwr      = 1'b0;
        w_memwr      = 1'b0;
        w_memrd      = 1'b0;
        case (r_state)
            c_ST_IDLE:      if (Start) w_state_next = c_ST_FETCH;
            c_ST_FETCH:     w_state_next = c_ST_DECODE;
            c_ST_DECODE:    w_state_next = (r_ir == HALT_WORD) ? c_ST_DONE : c_ST_EXECUTE;
            c_ST_EXECUTE: begin
                w_memwr      = w_is_str;
                w_memrd      = w_is_load;
                w_state_next = c_ST_WRITEBACK;
            end
            c_ST_WRITEBACK: begin
                w_regwr      = !(w_is_str || w_is_btru || w_is_b);
                w_memrd      = w_is_load;
                w_state_next = c_ST_FETCH;
            end
            c_ST_DONE:      if (Start) w_state_next = c_ST_FETCH;
            default:        w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_ir        <= 9'd0;
            r_pc        <= '0;
            r_cnt       <= 16'd0;
            r_take_br   <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_start_run)
                r_cnt <= 16'd0;
            else if (w_busy && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + 16'd1;

            if (w_start_run)
                r_pc <= '0;
            else if (r_state == c_ST_WRITEBACK)
                r_pc <= w_pc_next;

            if (r_state == c_ST_FETCH)
                r_ir <= InstrIn;

            // Branch decision is taken while AluZero is valid and used a cycle later
            if (r_state == c_ST_EXECUTE) begin
                r_take_br   <= w_is_btru && !AluZero;
                r_br_target <= w_bt;
            end
        end
    end

    assign PC         = r_pc;
    assign OpType     = w_is_itype;
    assign ROperand   = w_is_itype ? 4'd0 : r_ir[7:4];
    assign IOperand   = w_is_itype ? r_ir[7:5] : 3'd0;
    assign Immediate  = w_is_itype ? r_ir[4:0] : 5'd0;
    assign RegAddrA   = w_is_itype ? 2'd0 : r_ir[3:2];
    assign RegAddrB   = w_is_itype ? 2'd0 : r_ir[1:0];
    assign RegWrEn    = w_regwr;
    assign MemWrEn    = w_memwr;
    assign MemRdEn    = w_memrd;
    assign Busy       = w_busy;
    assign Done       = (r_state == c_ST_DONE);
    assign CycleCount = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_sequencer
//  Description : Directed self-checking bench for instruction_sequencer.
//                A bench-side ROM array feeds InstrIn; AluZero and
//                BranchTarget are driven per instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

    localparam logic [8:0] c_ADDI1 = 9'h101;   // ADDI imm=1
    localparam logic [8:0] c_ADDI5 = 9'h105;   // ADDI imm=5
    localparam logic [8:0] c_B_M2  = 9'h1DE;   // B imm=5'b11110 (-2)
    localparam logic [8:0] c_STR   = 9'h0D6;   // STR  A=1 B=2
    localparam logic [8:0] c_LOAD  = 9'h0C3;   // LOAD A=0 B=3
    localparam logic [8:0] c_BTRU  = 9'h0E1;   // BTRU A=0 B=1
    localparam logic [8:0] c_HALT  = 9'h1FF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  InstrIn;
    logic        AluZero;
    logic [7:0]  BranchTarget;
    logic [7:0]  PC;
    logic        OpType;
    logic [3:0]  ROperand;
    logic [2:0]  IOperand;
    logic [4:0]  Immediate;
    logic [1:0]  RegAddrA;
    logic [1:0]  RegAddrB;
    logic        RegWrEn;
    logic        MemWrEn;
    logic        MemRdEn;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom [0:255];
    int          checks = 0;
    int          errors = 0;

    assign InstrIn = rom[PC];

    always #5 Clk = ~Clk;

    instruction_sequencer #(.PCW(8), .HALT_WORD(9'h1FF)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .InstrIn      (InstrIn),
        .AluZero      (AluZero),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .OpType       (OpType),
        .ROperand     (ROperand),
        .IOperand     (IOperand),
        .Immediate    (Immediate),
        .RegAddrA     (RegAddrA),
        .RegAddrB     (RegAddrB),
        .RegWrEn      (RegWrEn),
        .MemWrEn      (MemWrEn),
        .MemRdEn      (MemRdEn),
        .Busy         (Busy),
        .Done         (Done),
        .CycleCount   (CycleCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // Entered at the negedge inside FETCH; leaves at the negedge inside the
    // next FETCH after checking every phase of one four-cycle instruction.
    task automatic run_instr(input string tag, input logic [7:0] pc_exp,
                             input logic regwr_wb, input logic memwr_ex,
                             input logic memrd, input logic [7:0] pc_next);
        chk({tag, ".fetch_pc"}, 32'(PC), 32'(pc_exp));
        chk({tag, ".fetch_busy"}, 32'(Busy), 32'd1);
        chk({tag, ".fetch_strobes"}, {29'd0, RegWrEn, MemWrEn, MemRdEn}, 32'd0);
        step();
        chk({tag, ".dec_strobes"}, {29'd0, RegWrEn, MemWrEn, MemRdEn}, 32'd0);
        step();
        chk({tag, ".ex_strobes"}, {29'd0, RegWrEn, MemWrEn, MemRdEn},
            {29'd0, 1'b0, memwr_ex, memrd});
        step();
        chk({tag, ".wb_strobes"}, {29'd0, RegWrEn, MemWrEn, MemRdEn},
            {29'd0, regwr_wb, 1'b0, memrd});
        step();
        chk({tag, ".next_pc"}, 32'(PC), 32'(pc_next));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = c_HALT;
        Reset        = 1'b1;
        Start        = 1'b0;
        AluZero      = 1'b0;
        BranchTarget = 8'h00;

        // ---- reset state, then idle with no Start ----
        #3;
        chk("rst.pc", 32'(PC), 32'd0);
        chk("rst.status", {30'd0, Busy, Done}, 32'd0);
        step(); step();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.pc", 32'(PC), 32'd0);
            chk("idle.status", {30'd0, Busy, Done}, 32'd0);
            chk("idle.strobes", {29'd0, RegWrEn, MemWrEn, MemRdEn}, 32'd0);
        end

        // ---- ADDI imm=5 then halt ----
        rom[0] = c_ADDI5;
        rom[1] = c_HALT;
        Start = 1'b1;
        step();                                    // cycle 1: FETCH
        Start = 1'b0;
        chk("addi.c1_busy", 32'(Busy), 32'd1);
        chk("addi.c1_regwr", 32'(RegWrEn), 32'd0);
        step();                                    // cycle 2: DECODE
        chk("addi.c2_fields", {20'd0, OpType, IOperand, Immediate, 3'd0},
            {20'd0, 1'b1, 3'b000, 5'd5, 3'd0});
        chk("addi.c2_regwr", 32'(RegWrEn), 32'd0);
        step();                                    // cycle 3: EXECUTE
        chk("addi.c3_regwr", 32'(RegWrEn), 32'd0);
        chk("addi.c3_imm", 32'(Immediate), 32'd5);
        step();                                    // cycle 4: WRITEBACK
        chk("addi.c4_regwr", 32'(RegWrEn), 32'd1);
        chk("addi.c4_mem", {30'd0, MemWrEn, MemRdEn}, 32'd0);
        step();                                    // cycle 5: FETCH
        chk("addi.c5_pc", 32'(PC), 32'd1);
        chk("addi.c5_regwr", 32'(RegWrEn), 32'd0);
        step();                                    // cycle 6: DECODE halt
        chk("addi.c6_status", {30'd0, Busy, Done}, 32'b10);
        step();                                    // DONE
        chk("addi.done_status", {30'd0, Busy, Done}, 32'b01);
        chk("addi.cycles", 32'(CycleCount), 32'd6);
        step();
        chk("addi.cycles_hold", 32'(CycleCount), 32'd6);

        // ---- program exercising B, STR, LOAD, BTRU ----
        rom[0]    = c_ADDI1;
        rom[1]    = c_ADDI1;
        rom[2]    = c_ADDI1;
        rom[3]    = c_ADDI1;
        rom[4]    = c_B_M2;
        rom[5]    = c_STR;
        rom[6]    = c_LOAD;
        rom[7]    = c_BTRU;
        rom[8]    = c_HALT;
        rom[8'h20] = c_BTRU;
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("prog.count_clear", 32'(CycleCount), 32'd0);
        run_instr("p0", 8'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        Start = 1'b1;                              // ignored while busy
        run_instr("p1_start_ignored", 8'd1, 1'b1, 1'b0, 1'b0, 8'd2);
        Start = 1'b0;
        run_instr("p2", 8'd2, 1'b1, 1'b0, 1'b0, 8'd3);
        run_instr("p3", 8'd3, 1'b1, 1'b0, 1'b0, 8'd4);
        run_instr("b_back", 8'd4, 1'b0, 1'b0, 1'b0, 8'd2);
        rom[4] = c_ADDI1;
        run_instr("p2b", 8'd2, 1'b1, 1'b0, 1'b0, 8'd3);
        run_instr("p3b", 8'd3, 1'b1, 1'b0, 1'b0, 8'd4);
        run_instr("p4b", 8'd4, 1'b1, 1'b0, 1'b0, 8'd5);
        run_instr("str", 8'd5, 1'b0, 1'b1, 1'b0, 8'd6);
        run_instr("load", 8'd6, 1'b1, 1'b0, 1'b1, 8'd7);
        AluZero = 1'b0; BranchTarget = 8'h20;
        run_instr("btru_taken", 8'd7, 1'b0, 1'b0, 1'b0, 8'h20);
        AluZero = 1'b0; BranchTarget = 8'h07;
        run_instr("btru_back", 8'h20, 1'b0, 1'b0, 1'b0, 8'd7);
        AluZero = 1'b1; BranchTarget = 8'h20;
        run_instr("btru_not_taken", 8'd7, 1'b0, 1'b0, 1'b0, 8'd8);
        AluZero = 1'b0;
        step(); step();
        chk("prog.done", {30'd0, Busy, Done}, 32'b01);
        chk("prog.cycles", 32'(CycleCount), 32'd54);

        // ---- reset during EXECUTE of ADDI ----
        rom[0] = c_ADDI5;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step(); step();                            // now in EXECUTE
        chk("rstex.pre_optype", 32'(OpType), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rstex.outputs", {11'd0, PC, OpType, IOperand, Immediate, RegWrEn, Busy, Done},
            32'd0);
        chk("rstex.cycles", 32'(CycleCount), 32'd0);
        step();
        chk("rstex.held_regwr", 32'(RegWrEn), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstex.no_regwr", {30'd0, RegWrEn, Busy}, 32'd0);
        end

        // ---- PC wrap from 8'hFF ----
        rom[0]    = c_BTRU;
        rom[8'hFF] = c_ADDI1;
        AluZero = 1'b0; BranchTarget = 8'hFF;
        Start = 1'b1;
        step();
        Start = 1'b0;
        run_instr("jump_ff", 8'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
        run_instr("wrap", 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0);

        Reset = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
